music_rom_player: RTL

- Sequencer at the reading end of the music note ROM (synchronous, 1-cycle read latency, registered output).
- Walks the note table from address 0, fetches a 2-word note record, plays the tone on a square-wave buzzer output for the encoded duration, then fetches the next record.
- Start, stop and loop are driven by the SoC's APB/AHB register block; `buzzer_o` goes to a pad.

---
 rtl/music_pkg.sv | 29 ++
 rtl/music_rom_player_if.sv | 44 ++++
 rtl/music_tone_gen.sv | 94 +++++++++
 rtl/music_rom_player.sv | 115 +++++++++++
 4 files changed

// File: rtl/music_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | music_pkg                                                            |
// | Shared state encoding and note-record constants for the ROM player.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package music_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_P  = 3'd1,
    ST_WAIT_P = 3'd2,
    ST_REQ_D  = 3'd3,
    ST_WAIT_D = 3'd4,
    ST_PLAY   = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  localparam logic [11:0] END_MARK    = 12'hFFF;
  localparam logic [11:0] REST_PERIOD = 12'h000;
  localparam logic [11:0] SKIP_DUR    = 12'h000;

  // A record is two consecutive words: half-period, then duration.
  localparam int unsigned PERIOD_OFS = 0;
  localparam int unsigned DUR_OFS    = 1;
  localparam int unsigned REC_WORDS  = 2;

endpackage
`default_nettype wire

// File: rtl/music_rom_player_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | music_rom_player_if                                                  |
// | Control, ROM read port and pad outputs of the note sequencer.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface music_rom_player_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 12
);

  logic                  start_i;
  logic                  stop_i;
  logic                  loop_i;
  logic [ADDR_WIDTH-1:0] rom_addr_o;
  logic [DATA_WIDTH-1:0] rom_data_i;
  logic                  buzzer_o;
  logic                  busy_o;
  logic                  done_o;

  modport slave (
    input  start_i,
    input  stop_i,
    input  loop_i,
    input  rom_data_i,
    output rom_addr_o,
    output buzzer_o,
    output busy_o,
    output done_o
  );

  modport master (
    output start_i,
    output stop_i,
    output loop_i,
    output rom_data_i,
    input  rom_addr_o,
    input  buzzer_o,
    input  busy_o,
    input  done_o
  );

endinterface
`default_nettype wire

// File: rtl/music_tone_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | music_tone_gen                                                       |
// | Tick prescaler, half-period square wave and note length countdown.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module music_tone_gen
  import music_pkg::*;
#(
  parameter int TICK_DIV = 50,
  parameter int BEAT_DIV = 10000
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        en,
  input  wire logic        clr,
  input  wire logic [11:0] period,
  input  wire logic [11:0] dur,
  output logic             wave,
  output logic             note_end
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BEAT_W  = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(BEAT_DIV - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [11:0]        half_q, half_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [11:0]        dcnt_q, dcnt_d;
  logic               wave_q, wave_d;
  logic               tick;
  logic               beat_wrap;
  logic               half_wrap;

  assign tick      = en && (presc_q == PRESC_LAST);
  assign beat_wrap = (beat_q == BEAT_LAST);
  assign half_wrap = (half_q == (period - 12'd1));
  // Kept apart from the next-state logic: clr is derived from note_end upstream.
  assign note_end  = tick && beat_wrap && (dcnt_q == (dur - 12'd1));
  assign wave      = wave_q;

  always_comb begin
    presc_d = presc_q;
    half_d  = half_q;
    beat_d  = beat_q;
    dcnt_d  = dcnt_q;
    wave_d  = wave_q;
    if (clr) begin
      presc_d = '0;
      half_d  = '0;
      beat_d  = '0;
      dcnt_d  = '0;
      wave_d  = 1'b0;
    end else if (en) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        if (period != REST_PERIOD) begin
          if (half_wrap) begin
            half_d = '0;
            wave_d = ~wave_q;
          end else begin
            half_d = half_q + 12'd1;
          end
        end
        if (beat_wrap) begin
          beat_d = '0;
          dcnt_d = dcnt_q + 12'd1;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      half_q  <= '0;
      beat_q  <= '0;
      dcnt_q  <= '0;
      wave_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      half_q  <= half_d;
      beat_q  <= beat_d;
      dcnt_q  <= dcnt_d;
      wave_q  <= wave_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/music_rom_player.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | music_rom_player                                                     |
// | Fetches two-word note records from a 1-cycle ROM and plays them.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module music_rom_player
  import music_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 12,
  parameter int TICK_DIV   = 50,
  parameter int BEAT_DIV   = 10000
) (
  input wire logic            clk,
  input wire logic            rst,
  music_rom_player_if.slave   bus
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] period_q, period_d;
  logic [DATA_WIDTH-1:0] dur_q, dur_d;
  logic                  tone_en;
  logic                  tone_clr;
  logic                  note_end;
  logic                  wave;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    period_d = period_q;
    dur_d    = dur_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          addr_d  = ADDR_WIDTH'(PERIOD_OFS);
          state_d = ST_REQ_P;
        end
      end
      ST_REQ_P: state_d = ST_WAIT_P;
      ST_WAIT_P: begin
        period_d = bus.rom_data_i;
        if (bus.rom_data_i == END_MARK) begin
          if (bus.loop_i) begin
            addr_d  = ADDR_WIDTH'(PERIOD_OFS);
            state_d = ST_REQ_P;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(DUR_OFS - PERIOD_OFS);
          state_d = ST_REQ_D;
        end
      end
      ST_REQ_D: state_d = ST_WAIT_D;
      ST_WAIT_D: begin
        dur_d   = bus.rom_data_i;
        addr_d  = addr_q + ADDR_WIDTH'(REC_WORDS - DUR_OFS);
        state_d = (bus.rom_data_i == SKIP_DUR) ? ST_REQ_P : ST_PLAY;
      end
      ST_PLAY: begin
        if (note_end) begin
          state_d = ST_REQ_P;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort beats every other request, including a simultaneous start.
    if (bus.stop_i) begin
      state_d = ST_IDLE;
      addr_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      period_q <= '0;
      dur_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      period_q <= period_d;
      dur_q    <= dur_d;
    end
  end

  // Clearing on the way out of PLAY silences the pad on the same edge.
  assign tone_en  = (state_q == ST_PLAY);
  assign tone_clr = (state_d != ST_PLAY);

  music_tone_gen #(
    .TICK_DIV (TICK_DIV),
    .BEAT_DIV (BEAT_DIV)
  ) u_tone_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (tone_en),
    .clr      (tone_clr),
    .period   (period_q),
    .dur      (dur_q),
    .wave     (wave),
    .note_end (note_end)
  );

  assign bus.rom_addr_o = addr_q;
  assign bus.buzzer_o   = wave;
  assign bus.busy_o     = (state_q != ST_IDLE);
  assign bus.done_o     = (state_q == ST_DONE);

endmodule
`default_nettype wire
